// File: rtl/keyboard_poll_ctrl.sv
// Keyboard poll controller: periodic device read strobe, key-code FIFO, CPU data/status registers.
// Optional macro KBD_IRQ_EN adds a registered irq output that is high while the FIFO holds data.
module keyboard_poll_ctrl #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        dev_read,
  input  logic [31:0] dev_data,
  input  logic        cpu_read,
  input  logic        cpu_addr,
  output logic [31:0] cpu_data_out
`ifdef KBD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CntW = $clog2(POLL_INTERVAL);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] Reload = CntW'(POLL_INTERVAL - 1);
  localparam logic [6:0] DepthCnt = 7'(FIFO_DEPTH);

  typedef enum logic {StWait, StReq} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dev_read_q, dev_read_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [6:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            empty, full, push, pop, wr_en, status_rd, irq_pend;
  logic [31:0]     rdata;
  logic            unused_dev_low;

  assign unused_dev_low = ^dev_data[23:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StReq;
          cnt_d   = Reload;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReq:   state_d = StWait;
      default: state_d = StWait;
    endcase
    dev_read_d = (state_d == StReq);
  end

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DepthCnt);
    // The strobe cycle is the one whose closing edge samples dev_data.
    push      = dev_read_q && (dev_data[31:24] != 8'hFF);
    pop       = cpu_read && !cpu_addr && !empty;
    status_rd = cpu_read && cpu_addr;
    wr_en     = push && (!full || pop);
    rd_ptr_d  = pop   ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d  = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 7'd1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 7'd1;
    end
    ovf_d = (ovf_q && !status_rd) || (push && full && !pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StWait;
      cnt_q      <= Reload;
      dev_read_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dev_read_q <= dev_read_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= dev_data[31:24];
    end
  end

`ifdef KBD_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_d != '0);
    end
  end
  assign irq      = irq_q;
  assign irq_pend = irq_q;
`else
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    if (cpu_addr) begin
      rdata = {16'h0, irq_pend, ovf_q, full, empty, 1'b0, 4'h0, count_q};
    end else if (empty) begin
      rdata = 32'hFF00_0000;
    end else begin
      rdata = {mem_q[rd_ptr_q], 24'h0};
    end
  end

  assign dev_read     = dev_read_q;
  assign cpu_data_out = cpu_read ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_keyboard_poll_ctrl.sv
// Bench for keyboard_poll_ctrl: queue-based reference model checked every cycle, directed and random.
module tb_keyboard_poll_ctrl;
  localparam int PI    = 4;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_addr = 1'b0;
  logic [31:0] dev_data = 32'h0;
  logic        dev_read;
  wire  [31:0] cpu_data_out;
`ifdef KBD_IRQ_EN
  logic        irq;
`endif

  always #5 clock = ~clock;

  keyboard_poll_ctrl #(
    .POLL_INTERVAL(PI),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dev_read    (dev_read),
    .dev_data    (dev_data),
    .cpu_read    (cpu_read),
    .cpu_addr    (cpu_addr),
    .cpu_data_out(cpu_data_out)
`ifdef KBD_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  // Reference model: cycles since reset, queued bytes, sticky overflow.
  int              phase;
  logic [7:0]      q[$];
  bit              ovf;
  bit              mvalid;
  int              total;
  int              bad;
  logic [31:0]     last_out;
  logic            last_dr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit exp_poll();
    return (phase % (PI + 1)) == PI;
  endfunction

  function automatic logic [31:0] exp_status();
    logic ip;
`ifdef KBD_IRQ_EN
    ip = (q.size() != 0);
`else
    ip = 1'b0;
`endif
    return {16'h0, ip, ovf, q.size() == DEPTH, q.size() == 0, 1'b0, 4'h0, 7'(q.size())};
  endfunction

  task automatic cyc(input logic rst, input logic rd, input logic ad, input logic [31:0] dd);
    bit capture, do_pop;
    @(negedge clock);
    reset    = rst;
    cpu_read = rd;
    cpu_addr = ad;
    dev_data = dd;
    #1;
    last_out = cpu_data_out;
    last_dr  = dev_read;
    if (mvalid) begin
      chk("dev_read", {31'b0, dev_read}, {31'b0, exp_poll()});
`ifdef KBD_IRQ_EN
      chk("irq", {31'b0, irq}, {31'b0, q.size() != 0});
`endif
      if (rd && ad) chk("status", cpu_data_out, exp_status());
      if (rd && !ad) chk("data", cpu_data_out, (q.size() != 0) ? {q[0], 24'h0} : 32'hFF00_0000);
    end
    @(posedge clock);
    if (rst) begin
      phase  = 0;
      q.delete();
      ovf    = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      capture = exp_poll() && (dd[31:24] != 8'hFF);
      do_pop  = rd && !ad && (q.size() != 0);
      if (rd && ad) ovf = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (capture) begin
        if (q.size() < DEPTH) q.push_back(dd[31:24]);
        else ovf = 1'b1;
      end
      phase++;
    end
  endtask

  function automatic logic [31:0] idle_data();
    return {8'hFF, 24'($urandom)};
  endfunction

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Idle until the model's strobe cycle, then drive the given data/access in it.
  task automatic poll(input logic [31:0] dd, input logic rst, input logic rd, input logic ad);
    int n = 0;
    while (!exp_poll() && n < 20) begin
      cyc(1'b0, 1'b0, 1'b0, idle_data());
      n++;
    end
    cyc(rst, rd, ad, dd);
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] dd;
    logic        rd;
    total  = 0;
    bad    = 0;
    mvalid = 1'b0;
    phase  = 0;
    ovf    = 1'b0;

    // Strobe cadence after reset: pulses at cycles 4 and 9.
    do_reset();
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, idle_data());
      pat[i] = last_dr;
    end
    chk("strobe_pattern", pat, 32'h0000_0210);

    do_reset();
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("reset_status", last_out, 32'h0000_1000);

    poll(32'h4100_0037, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("one_status", last_out, 32'h0000_0001);
    cyc(1'b0, 1'b1, 1'b0, idle_data());
    chk("one_data", last_out, 32'h4100_0000);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("drained_status", last_out, 32'h0000_1000);

    poll(32'hFF00_002A, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("discard_status", last_out, 32'h0000_1000);
    cyc(1'b0, 1'b1, 1'b0, idle_data());
    chk("empty_data", last_out, 32'hFF00_0000);

    do_reset();
    for (int v = 8'h10; v <= 8'h18; v++) poll({8'(v), 24'h0000AB}, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("ovf_status1", last_out, 32'h0000_6008);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("ovf_status2", last_out, 32'h0000_2008);
    for (int v = 8'h10; v <= 8'h17; v++) begin
      cyc(1'b0, 1'b1, 1'b0, idle_data());
      chk("order_data", last_out, {8'(v), 24'h0});
    end
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("order_empty", last_out, 32'h0000_1000);

    do_reset();
    for (int v = 8'h20; v <= 8'h27; v++) poll({8'(v), 24'h0}, 1'b0, 1'b0, 1'b0);
    poll(32'h5500_0000, 1'b0, 1'b1, 1'b0);
    chk("full_rw_data", last_out, 32'h2000_0000);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("full_rw_status", last_out, 32'h0000_2008);
    for (int v = 8'h21; v <= 8'h27; v++) begin
      cyc(1'b0, 1'b1, 1'b0, idle_data());
      chk("full_rw_order", last_out, {8'(v), 24'h0});
    end
    cyc(1'b0, 1'b1, 1'b0, idle_data());
    chk("full_rw_last", last_out, 32'h5500_0000);

    poll(32'h3300_0000, 1'b0, 1'b0, 1'b0);
    poll(32'h4400_0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, idle_data());
    chk("req_reset_strobe", {31'b0, last_dr}, 32'h0);
    chk("req_reset_status", last_out, 32'h0000_1000);

    for (int i = 0; i < 4000; i++) begin
      dd = $urandom;
      if ($urandom_range(1, 0) == 1) dd[31:24] = 8'hFF;
      rd = ($urandom % ((i < 2000) ? 14 : 3)) == 0;
      cyc(($urandom % 400) == 0, rd, 1'($urandom), dd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
